// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel array readout path: pixel/row types and readout FSM states.
// Array geometry defaults live here so the top and the serializer agree on them.
package pixel_readout_pkg;

    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int PIXEL_ARRAY_WIDTH  = 2;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [PIXEL_ARRAY_WIDTH-1:0] pixel_row_t;

    typedef enum logic [2:0] {
        RO_IDLE,
        RO_SELECT,
        RO_CAPTURE,
        RO_SHIFT,
        RO_DONE
    } readout_state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_row_serializer.sv
// Holds one captured row and presents its pixels, col 0 first, on a valid/ready byte stream.
// row_done marks the handshake of the final column.
module pixel_row_serializer
    import pixel_readout_pkg::*;
#(
    parameter int  WIDTH = PIXEL_ARRAY_WIDTH,
    localparam int COL_W = clog2_min1(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH*8-1:0] row_data,
    input  logic               ready,
    output logic               valid,
    output logic [7:0]         data,
    output logic [COL_W-1:0]   col,
    output logic               row_done
);

    pixel_t [WIDTH-1:0] row_buf_q;
    logic [COL_W-1:0]   col_q;
    logic               valid_q;
    logic               last_col;

    assign last_col = (col_q == COL_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_buf_q <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
        end else if (load) begin
            row_buf_q <= row_data;
            col_q     <= '0;
            valid_q   <= 1'b1;
        end else if (valid_q && ready) begin
            if (last_col) begin
                valid_q <= 1'b0;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign valid    = valid_q;
    assign data     = row_buf_q[col_q];
    assign col      = col_q;
    assign row_done = valid_q && ready && last_col;

endmodule

// File: rtl/pixel_readout.sv
// Frame readout: selects each array row, waits for the column bus to settle, captures it and
// streams the pixels. Define PIXEL_READOUT_CHECKSUM_EN to append an XOR checksum beat per frame.
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter int  HEIGHT        = PIXEL_ARRAY_HEIGHT,
    parameter int  WIDTH         = PIXEL_ARRAY_WIDTH,
    parameter int  SETTLE_CYCLES = 2,
    localparam int ROW_W         = clog2_min1(HEIGHT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [HEIGHT-1:0]  read_o,
    input  logic [WIDTH*8-1:0] row_data_i,
    output logic [7:0]         pix_data_o,
    output logic               pix_valid_o,
    input  logic               pix_ready_i,
    output logic               pix_first_o,
    output logic               pix_last_o,
    output logic [ROW_W-1:0]   pix_row_o,
    output logic [2:0]         state_o
);

    localparam int COL_W = clog2_min1(WIDTH);
    localparam int SET_W = clog2_min1(SETTLE_CYCLES);

    readout_state_t   state_q, state_d;
    logic [ROW_W-1:0] row_q;
    logic [SET_W-1:0] settle_q;
    logic             last_row;
    logic             settled;
    logic             start_accept;

    logic             ser_valid;
    logic [7:0]       ser_data;
    logic [COL_W-1:0] ser_col;
    logic             ser_row_done;

    assign last_row     = (row_q == ROW_W'(HEIGHT - 1));
    assign settled      = (settle_q == SET_W'(SETTLE_CYCLES - 1));
    assign start_accept = (state_q == RO_IDLE) && start_i;

    pixel_row_serializer #(.WIDTH(WIDTH)) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == RO_CAPTURE),
        .row_data (row_data_i),
        .ready    (pix_ready_i),
        .valid    (ser_valid),
        .data     (ser_data),
        .col      (ser_col),
        .row_done (ser_row_done)
    );

`ifdef PIXEL_READOUT_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       trailer_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q    <= '0;
            trailer_q <= 1'b0;
        end else begin
            if (start_accept) begin
                csum_q <= '0;
            end else if (ser_valid && pix_ready_i) begin
                csum_q <= csum_q ^ ser_data;
            end
            // The trailer beat follows the final pixel of the last row.
            if (state_q == RO_SHIFT && ser_row_done && last_row) begin
                trailer_q <= 1'b1;
            end else if (trailer_q && pix_ready_i) begin
                trailer_q <= 1'b0;
            end
        end
    end

    assign pix_valid_o = ser_valid | trailer_q;
    assign pix_data_o  = trailer_q ? csum_q : ser_data;
    assign pix_last_o  = trailer_q;
`else
    assign pix_valid_o = ser_valid;
    assign pix_data_o  = ser_data;
    assign pix_last_o  = ser_valid && last_row && (ser_col == COL_W'(WIDTH - 1));
`endif

    assign pix_first_o = ser_valid && (row_q == '0) && (ser_col == '0);
    assign pix_row_o   = row_q;
    assign state_o     = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RO_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != RO_IDLE) && (state_q != RO_DONE);
        done_o  = (state_q == RO_DONE);
        read_o  = '0;
        unique case (state_q)
            RO_IDLE: begin
                if (start_i) state_d = RO_SELECT;
            end
            RO_SELECT: begin
                read_o = HEIGHT'(1) << row_q;
                if (settled) state_d = RO_CAPTURE;
            end
            RO_CAPTURE: begin
                read_o  = HEIGHT'(1) << row_q;
                state_d = RO_SHIFT;
            end
            RO_SHIFT: begin
`ifdef PIXEL_READOUT_CHECKSUM_EN
                if (trailer_q) begin
                    if (pix_ready_i) state_d = RO_DONE;
                end else if (ser_row_done && !last_row) begin
                    state_d = RO_SELECT;
                end
`else
                if (ser_row_done) state_d = last_row ? RO_DONE : RO_SELECT;
`endif
            end
            RO_DONE: begin
                state_d = RO_IDLE;
            end
            default: begin
                state_d = RO_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q    <= '0;
            settle_q <= '0;
        end else begin
            if (start_accept) begin
                row_q    <= '0;
                settle_q <= '0;
            end
            if (state_q == RO_SELECT) begin
                settle_q <= settled ? '0 : settle_q + 1'b1;
            end
            if (state_q == RO_SHIFT && ser_row_done && !last_row) begin
                row_q <= row_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: an array model answers read_o, a frame model builds the expected
// byte stream, and a monitor records every handshake for comparison.
`timescale 1ns/1ps
module tb_pixel_readout;

    localparam int HEIGHT = 2;
    localparam int WIDTH  = 2;
    localparam int SETTLE = 2;
    localparam int ROW_W  = 1;
`ifdef PIXEL_READOUT_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif
    localparam int FRAME_BYTES = HEIGHT * WIDTH + CSUM;
    localparam int TW = 8 + ROW_W + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_i;
    logic               busy_o, done_o;
    logic [HEIGHT-1:0]  read_o;
    logic [WIDTH*8-1:0] row_data_i;
    logic [7:0]         pix_data_o;
    logic               pix_valid_o, pix_ready_i;
    logic               pix_first_o, pix_last_o;
    logic [ROW_W-1:0]   pix_row_o;
    logic [2:0]         state_o;

    int checks   = 0;
    int failures = 0;

    pixel_readout #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .read_o      (read_o),
        .row_data_i  (row_data_i),
        .pix_data_o  (pix_data_o),
        .pix_valid_o (pix_valid_o),
        .pix_ready_i (pix_ready_i),
        .pix_first_o (pix_first_o),
        .pix_last_o  (pix_last_o),
        .pix_row_o   (pix_row_o),
        .state_o     (state_o)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- pixel array model: bus shows the selected row (row 0 when nothing selected) ----
    logic [7:0] mem [HEIGHT][WIDTH];

    always_comb begin
        int sel;
        sel = 0;
        row_data_i = '0;
        for (int r = 0; r < HEIGHT; r++) if (read_o[r]) sel = r;
        for (int c = 0; c < WIDTH; c++) row_data_i[c*8 +: 8] = mem[sel][c];
    end

    // ---- sink ready driver: 0 = always ready, 1 = toggle, 2 = random ----
    int ready_mode = 0;

    initial begin
        pix_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       pix_ready_i = ~pix_ready_i;
                2:       pix_ready_i = 1'($urandom_range(0, 1));
                default: pix_ready_i = 1'b1;
            endcase
        end
    end

    // ---- monitor: handshakes, stall stability, read_o during streaming, done pulses ----
    logic [TW-1:0] obs_q[$];
    int            done_cnt      = 0;
    int            stall_viol    = 0;
    int            read_in_shift = 0;
    logic          prev_stall    = 1'b0;
    logic [TW-1:0] prev_word     = '0;
    logic [TW-1:0] cur_word;

    assign cur_word = {pix_first_o, pix_last_o, pix_row_o, pix_data_o};

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!pix_valid_o || cur_word != prev_word)) stall_viol++;
            if (pix_valid_o && read_o != '0) read_in_shift++;
            if (done_o) done_cnt++;
            if (pix_valid_o && pix_ready_i) obs_q.push_back(cur_word);
            prev_stall = pix_valid_o && !pix_ready_i;
            prev_word  = cur_word;
        end
    end

    // ---- reference model: frame bytes from the array contents ----
    logic [TW-1:0] exp_q[$];

    task automatic build_expected();
        logic [7:0] x;
        logic       first, last;
        x = 8'h00;
        exp_q.delete();
        for (int r = 0; r < HEIGHT; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                first = (r == 0) && (c == 0);
                last  = (CSUM == 0) && (r == HEIGHT - 1) && (c == WIDTH - 1);
                exp_q.push_back({first, last, ROW_W'(r), mem[r][c]});
                x = x ^ mem[r][c];
            end
        end
        if (CSUM != 0) exp_q.push_back({1'b0, 1'b1, ROW_W'(HEIGHT - 1), x});
    endtask

    // ---- driver tasks ----
    task automatic load_basic_rows();
        mem[0][0] = 8'h22; mem[0][1] = 8'h11;
        mem[1][0] = 8'h44; mem[1][1] = 8'h33;
    endtask

    task automatic load_random_rows();
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++) mem[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic clear_obs();
        obs_q.delete();
        done_cnt      = 0;
        stall_viol    = 0;
        read_in_shift = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Returns with time at the negedge of the cycle after done_o.
    task automatic wait_done(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (done_o) ok = 1'b1;
            n++;
        end
        @(negedge clk);
    endtask

    // ---- tests ----
    task automatic test_reset();
        reset   = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (read_o !== '0)        begin failures++; $display("FAIL reset_read got=%b exp=0", read_o); end
        checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pix_valid_o); end
        checks++; if (pix_data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", pix_data_o); end
        checks++; if (pix_first_o !== 1'b0 || pix_last_o !== 1'b0 || pix_row_o !== '0) begin
            failures++; $display("FAIL reset_flags got=%b%b%b exp=000", pix_first_o, pix_last_o, pix_row_o);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    endtask

    task automatic test_basic_frame();
        logic [HEIGHT-1:0] exp_rd[$];
        logic              exp_vld[$];
        int                n;
        load_basic_rows();
        ready_mode = 0;
        build_expected();
        for (int r = 0; r < HEIGHT; r++) begin
            repeat (SETTLE + 1) begin exp_rd.push_back(HEIGHT'(1) << r); exp_vld.push_back(1'b0); end
            repeat (WIDTH) begin exp_rd.push_back('0); exp_vld.push_back(1'b1); end
        end
        if (CSUM != 0) begin exp_rd.push_back('0); exp_vld.push_back(1'b1); end
        n = exp_rd.size();
        @(negedge clk);
        clear_obs();
        pulse_start();
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            checks++;
            if (k < n && (read_o !== exp_rd[k] || pix_valid_o !== exp_vld[k] || busy_o !== 1'b1 || done_o !== 1'b0)) begin
                failures++;
                $display("FAIL basic_cycle%0d got read=%b valid=%b busy=%b done=%b exp read=%b valid=%b busy=1 done=0",
                         k + 1, read_o, pix_valid_o, busy_o, done_o, exp_rd[k], exp_vld[k]);
            end else if (k == n && (read_o !== '0 || pix_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b1)) begin
                failures++;
                $display("FAIL basic_done_cycle got read=%b valid=%b busy=%b done=%b exp 0 0 0 1",
                         read_o, pix_valid_o, busy_o, done_o);
            end
        end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL basic_after got busy=%b done=%b exp 0 0", busy_o, done_o); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_frame_flags();
        bit ok;
        int last_idx;
        logic [7:0] last_byte;
        load_basic_rows();
        ready_mode = 0;
        last_idx  = (CSUM != 0) ? 4 : 3;
        last_byte = (CSUM != 0) ? 8'h44 : 8'h33;
        clear_obs();
        pulse_start();
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL flags_timeout got=no_done exp=done"); end
        checks++;
        if (obs_q.size() != last_idx + 1) begin
            failures++; $display("FAIL flags_count got=%0d exp=%0d", obs_q.size(), last_idx + 1);
        end else begin
            checks++;
            if (obs_q[last_idx][7:0] !== last_byte) begin
                failures++; $display("FAIL flags_last_byte got=%h exp=%h", obs_q[last_idx][7:0], last_byte);
            end
            for (int i = 0; i <= last_idx; i++) begin
                checks++;
                if (obs_q[i][TW-2] !== (i == last_idx) || obs_q[i][TW-1] !== (i == 0)) begin
                    failures++; $display("FAIL flags_byte%0d got first=%b last=%b exp first=%b last=%b",
                                         i, obs_q[i][TW-1], obs_q[i][TW-2], (i == 0), (i == last_idx));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        load_basic_rows();
        build_expected();
        clear_obs();
        ready_mode = 1;
        pulse_start();
        wait_done(ok);
        ready_mode = 0;
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
        checks++; if (stall_viol !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        checks++; if (read_in_shift !== 0) begin failures++; $display("FAIL bp_read_in_shift got=%0d exp=0", read_in_shift); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_start_held();
        bit ok;
        load_random_rows();
        build_expected();
        ready_mode = 0;
        @(negedge clk);
        clear_obs();
        start_i = 1'b1;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL held_timeout got=no_done exp=done"); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL held_done_count got=%0d exp=1", done_cnt); end
        checks++; if (obs_q.size() != FRAME_BYTES) begin failures++; $display("FAIL held_count got=%0d exp=%0d", obs_q.size(), FRAME_BYTES); end
        checks++; if (busy_o !== 1'b0 || read_o !== '0) begin failures++; $display("FAIL held_idle got busy=%b read=%b exp 0 0", busy_o, read_o); end
        @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL held_restart got=%b exp=1", busy_o); end
        start_i = 1'b0;
        wait_done(ok);
        checks++; if (!ok || done_cnt !== 2) begin failures++; $display("FAIL held_second_done got=%0d exp=2", done_cnt); end
        checks++;
        if (obs_q.size() != 2 * FRAME_BYTES) begin
            failures++; $display("FAIL held_total got=%0d exp=%0d", obs_q.size(), 2 * FRAME_BYTES);
        end else begin
            for (int i = 0; i < 2 * FRAME_BYTES; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i % FRAME_BYTES]) begin
                    failures++; $display("FAIL held_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i % FRAME_BYTES]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n;
        load_random_rows();
        ready_mode = 0;
        clear_obs();
        pulse_start();
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (pix_valid_o && pix_row_o == ROW_W'(1)) ok = 1'b1;
            n++;
        end
        checks++; if (!ok) begin failures++; $display("FAIL midrst_reach_row1 got=no exp=yes"); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || pix_valid_o !== 1'b0 || read_o !== '0 || done_o !== 1'b0 ||
            pix_data_o !== 8'h00 || pix_first_o !== 1'b0 || pix_last_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got busy=%b valid=%b read=%b done=%b data=%h exp all 0",
                     busy_o, pix_valid_o, read_o, done_o, pix_data_o);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        clear_obs();
        repeat (10) @(negedge clk);
        checks++; if (done_cnt !== 0 || busy_o !== 1'b0 || obs_q.size() != 0) begin
            failures++; $display("FAIL midrst_quiet got done=%0d busy=%b bytes=%0d exp 0 0 0", done_cnt, busy_o, obs_q.size());
        end
        load_random_rows();
        build_expected();
        pulse_start();
        wait_done(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL midrst_next_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_bus_change();
        bit ok;
        int n;
        load_basic_rows();
        build_expected();
        ready_mode = 0;
        clear_obs();
        pulse_start();
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (pix_valid_o) ok = 1'b1;
            n++;
        end
        mem[0][0] = 8'hFF;
        mem[0][1] = 8'hFF;
        wait_done(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL bus_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bus_byte%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        for (int it = 0; it < 6; it++) begin
            load_random_rows();
            build_expected();
            clear_obs();
            ready_mode = 2;
            pulse_start();
            wait_done(ok);
            ready_mode = 0;
            checks++; if (stall_viol !== 0 || done_cnt !== 1) begin
                failures++; $display("FAIL rand%0d_protocol got stall=%0d done=%0d exp 0 1", it, stall_viol, done_cnt);
            end
            checks++;
            if (!ok || obs_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, i, obs_q[i], exp_q[i]); end
                end
            end
        end
    endtask

    // ---- sequence and report ----
    initial begin
        start_i = 1'b0;
        test_reset();
        test_basic_frame();
        test_frame_flags();
        test_backpressure();
        test_start_held();
        test_reset_mid_frame();
        test_bus_change();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
